iomem_gpio_padctrl: RTL
=======================

Name: iomem_gpio_padctrl

Overview:
Parametrised GPIO controller that sits between the picosoc iomem bus and the SoC pad ring.
- Drives per-channel output-data and output-enable nets to bidirectional pad cells.
- Synchronises the pad-to-core inputs.
- Raises a level interrupt on a selected input edge.
- Generalises the fixed-function split di/oe/do pad wiring to NUM_GPIO software-controlled channels.

Parameters:
NUM_GPIO, 16, number of GPIO channels (1..32).
BASE_ADDR, 32'h0300_0000, iomem base address; the block decodes a 32-byte window.
SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
clk  in  1  core clock
resetn  in  1  reset, asynchronous assert, active-low
iomem_valid  in  1  bus request
iomem_ready  out  1  bus acknowledge, one-cycle pulse
iomem_wstrb  in  4  byte write strobes; 0 means read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1, otherwise 0
gpio_di  in  NUM_GPIO  pad-to-core input values (asynchronous)
gpio_do  out  NUM_GPIO  core-to-pad output values
gpio_oe  out  NUM_GPIO  pad output enables, 1 = drive
irq  out  1  level interrupt, registered

Behaviour:
- Clocking and reset: single clock clk. resetn is asynchronous and active-low. All flops reset to 0.
- Reset values: gpio_do=0, gpio_oe=0 (all pads input), iomem_ready=0, iomem_rdata=0, irq=0.
- Address hit: iomem_addr[31:5]==BASE_ADDR[31:5]. Register offset = iomem_addr[4:2].
- Register map:
  - 0x00 OUT (RW): drives gpio_do.
  - 0x04 OE (RW): drives gpio_oe.
  - 0x08 IN (RO): synchronised input.
  - 0x0C IRQ_EN (RW).
  - 0x10 IRQ_STAT (W1C).
  - 0x14 IRQ_EDGE (RW): 1 = rising, 0 = falling.
  - 0x18 and 0x1C: read 0, writes ignored, still acknowledged.
- Bits [31:NUM_GPIO] of every register read 0; writes to them are ignored.
- Bus FSM:
  - IDLE: on iomem_valid & hit & !iomem_ready, go to ACK. Write applied per byte on wstrb at that clock edge; rdata captured.
  - ACK: iomem_ready=1 for exactly one cycle, then IDLE.
  - Latency: ready one cycle after valid is sampled.
  - The master may hold valid across ACK. The FSM does not re-trigger in the cycle where ready=1.
  - On a non-hit address, ready stays 0 (another slave responds).
- Input path: SYNC_STAGES-flop synchroniser per channel, then a prev-sample flop. IN reflects the final synchroniser stage.
- Edge detect, per channel i:
  - Rising: sync & ~prev. Falling: ~sync & prev. Selected by IRQ_EDGE[i].
  - IRQ_STAT[i] sets on a selected edge only when IRQ_EN[i]=1.
  - Edge detect is independent of OE; outputs fed back through the pad are also detected.
- Start-up blanking: a counter suppresses edge detection for SYNC_STAGES+1 cycles after reset release. An input held high through reset does not raise a spurious rising event.
- Simultaneous set and W1C on the same bit in one cycle: set wins, bit stays 1.
- irq is registered: irq <= |(IRQ_STAT & IRQ_EN), i.e. 1 cycle after STAT/EN change. Clearing IRQ_EN masks irq but leaves STAT intact.
- Reset asserted mid-transaction: FSM returns to IDLE, ready=0, no partial write persists.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Adds parameter DEBOUNCE_CYCLES (default 8) and a per-channel counter after the synchroniser.
  - The filtered value updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion resets the counter.
  - IN and edge detection use the filtered value.
  - Adds RW register 0x18 DB_EN, reset 0. Channels with DB_EN[i]=0 bypass the filter.
- Not defined: the synchronised value is used directly; 0x18 reads 0.

Decomposition:
- Package gpio_pkg: register offset localparams (OFS_OUT..OFS_EDGE, OFS_DBEN), ADDR_WIN_BITS=5, bus FSM state enum {IDLE, ACK}.
- Sub-module gpio_sync_edge, one channel per instance, generated NUM_GPIO times. Contains the synchroniser, optional debounce, prev flop and edge outputs (rise, fall).
- Top level: register file, bus FSM, blanking counter, irq.

Test Plan:
- Reset: resetn=0 with gpio_di=all 1 → gpio_oe=0, gpio_do=0, irq=0. Release → no IRQ_STAT bits set after 10 cycles, even with IRQ_EN=0xFFFF written immediately.
- Write and read timing: write OE=0x00FF, OUT=0xA5A5 with wstrb=4'b0001 → gpio_do=0x00A5, gpio_oe=0x00FF. Each access acknowledged with ready high exactly 1 cycle, 1 cycle after valid.
- Rising interrupt: IRQ_EN[3]=1, IRQ_EDGE[3]=1, drive gpio_di[3] 0→1 → IN[3]=1 after SYNC_STAGES cycles, IRQ_STAT=0x0008, irq=1 one cycle later. W1C 0x0008 → irq=0.
- Edge collision: pulse gpio_di[5] falling with EDGE[5]=0 timed so the edge lands in the same cycle as the W1C write of bit 5 → STAT[5] stays 1.
- Decode: access addr BASE_ADDR+0x40 → ready never asserts within 8 cycles. Access BASE_ADDR+0x1C → ready after 1 cycle, rdata=0. Write 0xFFFF_FFFF to OUT with NUM_GPIO=16 → readback 0x0000_FFFF.
- Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8, DB_EN[0]=1): 5-cycle glitch on gpio_di[0] → IN[0] unchanged, no IRQ. 12-cycle high level → IN[0]=1 after SYNC_STAGES+8 cycles.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the iomem GPIO pad controller:
//   - ADDR_WIN_BITS : width of the byte-address window decoded by the block
//   - OFS_*         : register word offsets (iomem_addr[4:2])
//   - bus_state_t   : bus handshake FSM states
//   - strb_merge    : byte-strobe merge of write data into a 32-bit word
//   - strb_mask     : 32-bit mask with one byte lane per strobe bit
// Optional feature macro: GPIO_DEBOUNCE_EN (OFS_DBEN is only decoded then).

package gpio_pkg;

    localparam int ADDR_WIN_BITS = 5;

    localparam logic [2:0] OFS_OUT      = 3'd0;
    localparam logic [2:0] OFS_OE       = 3'd1;
    localparam logic [2:0] OFS_IN       = 3'd2;
    localparam logic [2:0] OFS_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFS_IRQ_STAT = 3'd4;
    localparam logic [2:0] OFS_EDGE     = 3'd5;
    localparam logic [2:0] OFS_DBEN     = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wstrb);
        logic [31:0] mask;
        mask = strb_mask(wstrb);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// One GPIO input channel: SYNC_STAGES-deep synchroniser, optional debounce
// filter, previous-sample flop and edge pulses.
// Ports:
//   clk, resetn  : core clock, asynchronous active-low reset
//   di           : raw asynchronous pad input
//   db_en        : selects the debounced value (GPIO_DEBOUNCE_EN builds only)
//   level        : synchronised (or filtered) input value
//   rise, fall   : single-cycle edge indications on level
// Optional feature macro: GPIO_DEBOUNCE_EN adds DEBOUNCE_CYCLES and db_en.

module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 8
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic di,
`ifdef GPIO_DEBOUNCE_EN
    input  logic db_en,
`endif
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_val;
    logic                   prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], di};
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_q;
    logic             filt_q;

    // The filtered value follows the synchronised input only once it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync_val == filt_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_q   <= sync_val;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign level = db_en ? filt_q : sync_val;
`else
    assign level = sync_val;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/iomem_gpio_padctrl.sv
// iomem_gpio_padctrl
// GPIO controller between the picosoc iomem bus and the pad ring. Holds the
// OUT/OE/IRQ_EN/IRQ_STAT/IRQ_EDGE registers, answers bus accesses with a
// one-cycle ready pulse and raises a registered level interrupt.
// Ports:
//   clk, resetn       : core clock, asynchronous active-low reset
//   iomem_valid       : bus request
//   iomem_ready       : one-cycle acknowledge, one cycle after valid is sampled
//   iomem_wstrb       : byte write strobes, 0 = read
//   iomem_addr        : byte address, 32-byte window at BASE_ADDR
//   iomem_wdata       : write data
//   iomem_rdata       : read data while ready=1, otherwise 0
//   gpio_di           : asynchronous pad inputs
//   gpio_do, gpio_oe  : pad output values and output enables
//   irq               : level interrupt
// Optional feature macro: GPIO_DEBOUNCE_EN adds DEBOUNCE_CYCLES and DB_EN (0x18).

module iomem_gpio_padctrl
    import gpio_pkg::*;
#(
    parameter int          NUM_GPIO    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int          SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int        DEBOUNCE_CYCLES = 8
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic [NUM_GPIO-1:0] gpio_di,
    output logic [NUM_GPIO-1:0] gpio_do,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                irq
);

    localparam int BLANK_CYCLES = SYNC_STAGES + 1;
    localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);

    bus_state_t state_q, state_d;

    logic [NUM_GPIO-1:0] out_q, oe_q, irq_en_q, stat_q, stat_d, edge_sel_q;
    logic [NUM_GPIO-1:0] sync_in, rise, fall, edge_evt, clr_mask;
    logic [31:0]         rdata_q, read_val;
    logic [BLANK_W-1:0]  blank_cnt_q;
    logic                blank;
    logic                hit, access, wr_en;
    logic [2:0]          ofs;
    logic                irq_q;
    logic                unused_addr_bits;

`ifdef GPIO_DEBOUNCE_EN
    logic [NUM_GPIO-1:0] db_en_q;
`endif

    assign hit    = (iomem_addr[31:ADDR_WIN_BITS] == BASE_ADDR[31:ADDR_WIN_BITS]);
    assign ofs    = iomem_addr[4:2];
    assign access = iomem_valid && hit && (state_q == IDLE);
    assign wr_en  = access && (iomem_wstrb != 4'b0000);

    // Byte lanes below the word boundary carry no register selection.
    assign unused_addr_bits = ^iomem_addr[1:0];

    // Per-channel input conditioning and edge detection.
    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_chan
        gpio_sync_edge #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_chan (
            .clk    (clk),
            .resetn (resetn),
            .di     (gpio_di[i]),
`ifdef GPIO_DEBOUNCE_EN
            .db_en  (db_en_q[i]),
`endif
            .level  (sync_in[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign edge_evt = (edge_sel_q & rise) | (~edge_sel_q & fall);

    // Bus handshake: accept in IDLE, acknowledge for exactly one cycle in ACK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign iomem_ready = (state_q == ACK);

    // Read mux; unmapped offsets and bits above NUM_GPIO read as zero.
    always_comb begin
        read_val = '0;
        case (ofs)
            OFS_OUT:      read_val = 32'(out_q);
            OFS_OE:       read_val = 32'(oe_q);
            OFS_IN:       read_val = 32'(sync_in);
            OFS_IRQ_EN:   read_val = 32'(irq_en_q);
            OFS_IRQ_STAT: read_val = 32'(stat_q);
            OFS_EDGE:     read_val = 32'(edge_sel_q);
`ifdef GPIO_DEBOUNCE_EN
            OFS_DBEN:     read_val = 32'(db_en_q);
`endif
            default:      read_val = '0;
        endcase
    end

    // Read data is only non-zero during the ACK cycle that follows capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= access ? read_val : 32'h0;
        end
    end

    assign iomem_rdata = rdata_q;

    // Edge detection is held off until the synchroniser and prev flop hold
    // post-reset samples, so inputs high through reset do not look like edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_cnt_q <= '0;
        end else if (blank) begin
            blank_cnt_q <= blank_cnt_q + 1'b1;
        end
    end

    assign blank = (blank_cnt_q != BLANK_W'(BLANK_CYCLES));

    // Status update: W1C applied first, then new events OR'd in so a
    // coincident event wins over the clear.
    assign clr_mask = (wr_en && ofs == OFS_IRQ_STAT)
                    ? NUM_GPIO'(iomem_wdata & strb_mask(iomem_wstrb))
                    : '0;

    always_comb begin
        stat_d = stat_q & ~clr_mask;
        if (!blank) begin
            stat_d = stat_d | (edge_evt & irq_en_q);
        end
    end

    // Software-written registers, byte-strobed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q      <= '0;
            oe_q       <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
`ifdef GPIO_DEBOUNCE_EN
            db_en_q    <= '0;
`endif
        end else if (wr_en) begin
            case (ofs)
                OFS_OUT:    out_q      <= NUM_GPIO'(strb_merge(32'(out_q), iomem_wdata, iomem_wstrb));
                OFS_OE:     oe_q       <= NUM_GPIO'(strb_merge(32'(oe_q), iomem_wdata, iomem_wstrb));
                OFS_IRQ_EN: irq_en_q   <= NUM_GPIO'(strb_merge(32'(irq_en_q), iomem_wdata, iomem_wstrb));
                OFS_EDGE:   edge_sel_q <= NUM_GPIO'(strb_merge(32'(edge_sel_q), iomem_wdata, iomem_wstrb));
`ifdef GPIO_DEBOUNCE_EN
                OFS_DBEN:   db_en_q    <= NUM_GPIO'(strb_merge(32'(db_en_q), iomem_wdata, iomem_wstrb));
`endif
                default:    ;
            endcase
        end
    end

    // Status register and registered interrupt level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            irq_q  <= |(stat_q & irq_en_q);
        end
    end

    assign gpio_do = out_q;
    assign gpio_oe = oe_q;
    assign irq     = irq_q;

endmodule
